rcastudioii_cart_loader: RTL and testbench

//  Multi-slot cartridge download engine between hps_io ioctl stream and the console's cartridge/BIOS BRAMs.

---
 rtl/rcastudioii_pkg.sv | 14 +
 rtl/rcastudioii_cart_loader_if.sv | 26 ++
 rtl/rcastudioii_cart_loader.sv | 161 ++++++++++++++++
 tb/tb_rcastudioii_cart_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rcastudioii_pkg.sv
// Shared types and defaults for the RCA Studio II cartridge download engine.
package rcastudioii_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } loader_state_t;

   localparam logic [7:0] CART_INDEX_BASE   = 8'h01;
   localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/rcastudioii_cart_loader_if.sv
// ioctl download stream in, BRAM write port out; hps side is master, loader is slave.
interface rcastudioii_cart_loader_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned SLOT_W = 1
);
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;

   logic              mem_wr;
   logic [SLOT_W-1:0] mem_slot;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  mem_wr, mem_slot, mem_addr, mem_data
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output mem_wr, mem_slot, mem_addr, mem_data
   );
endinterface

// File: rtl/rcastudioii_cart_loader.sv
// Multi-slot cartridge loader: routes each ioctl download to a BRAM slot, pads the
// tail with FILL_BYTE, holds the CPU while busy and reports per-slot status.
module rcastudioii_cart_loader
   import rcastudioii_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned NUM_SLOTS  = 2,
   parameter logic [7:0]  INDEX_BASE = CART_INDEX_BASE,
   parameter logic [7:0]  FILL_BYTE  = DEFAULT_FILL_BYTE
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   rcastudioii_cart_loader_if.slave bus,
   output logic                     cpu_hold,
   output logic [NUM_SLOTS-1:0]     cart_loaded,
   output logic [ADDR_W:0]          cart_size,
   output logic                     overflow,
   output logic                     load_done
);

   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_ADR = DEPTH - CNT_W'(1);

   loader_state_t          state_q, state_d;
   logic                   dl_q;
   logic [SLOT_W-1:0]      slot_q, slot_d;
   logic [NUM_SLOTS-1:0]   loaded_q, loaded_d;
   logic [CNT_W-1:0]       size_q, size_d;
   logic [CNT_W-1:0]       fill_q, fill_d;
   logic                   ovf_q, ovf_d;
   logic                   mem_wr_q, mem_wr_d;
   logic [SLOT_W-1:0]      mem_slot_q, mem_slot_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [7:0]             mem_data_q, mem_data_d;
   logic                   hold_q, hold_d;
   logic                   done_q, done_d;

   logic                   rise_c;
   logic [8:0]             idx_off_c;
   logic                   in_range_c;
   logic                   addr_ok_c;
   logic [CNT_W-1:0]       wr_end_c;

   // Download edge and index/address decode; 9-bit offset keeps indices below the base negative.
   assign rise_c     = bus.ioctl_download & ~dl_q;
   assign idx_off_c  = {1'b0, bus.ioctl_index} - {1'b0, INDEX_BASE};
   assign in_range_c = ~idx_off_c[8] && (idx_off_c < 9'(NUM_SLOTS));
   assign addr_ok_c  = ((bus.ioctl_addr >> ADDR_W) == '0);
   assign wr_end_c   = {1'b0, bus.ioctl_addr[ADDR_W-1:0]} + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      loaded_d   = loaded_q;
      size_d     = size_q;
      fill_d     = fill_q;
      ovf_d      = ovf_q;
      mem_wr_d   = 1'b0;
      mem_slot_d = mem_slot_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;

      unique case (state_q)
         LOAD: begin
            if (bus.ioctl_wr) begin
               if (addr_ok_c) begin
                  mem_wr_d   = 1'b1;
                  mem_slot_d = slot_q;
                  mem_addr_d = bus.ioctl_addr[ADDR_W-1:0];
                  mem_data_d = bus.ioctl_dout;
                  if (wr_end_c > size_q) size_d = wr_end_c;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            // A byte arriving with the falling edge is already folded into size_d.
            if (!bus.ioctl_download) begin
               state_d = FILL;
               fill_d  = size_d;
            end
         end
         FILL: begin
            if (!fill_q[ADDR_W]) begin
               mem_wr_d   = 1'b1;
               mem_slot_d = slot_q;
               mem_addr_d = fill_q[ADDR_W-1:0];
               mem_data_d = FILL_BYTE;
               fill_d     = fill_q + CNT_W'(1);
            end
            if (fill_q >= LAST_ADR) state_d = DONE;
         end
         DONE: begin
            loaded_d[slot_q] = (size_q != '0);
            state_d          = IDLE;
         end
         default: ;
      endcase

      // A new download start overrides whatever fill/done work is in flight.
      if (rise_c && (state_q != LOAD)) begin
         mem_wr_d = 1'b0;
         loaded_d = loaded_q;
         state_d  = IDLE;
         if (in_range_c) begin
            slot_d                          = idx_off_c[SLOT_W-1:0];
            loaded_d[idx_off_c[SLOT_W-1:0]] = 1'b0;
            size_d                          = '0;
            ovf_d                           = 1'b0;
            state_d                         = LOAD;
         end
      end

      hold_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         dl_q       <= 1'b0;
         slot_q     <= '0;
         loaded_q   <= '0;
         size_q     <= '0;
         fill_q     <= '0;
         ovf_q      <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_slot_q <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= bus.ioctl_download;
         slot_q     <= slot_d;
         loaded_q   <= loaded_d;
         size_q     <= size_d;
         fill_q     <= fill_d;
         ovf_q      <= ovf_d;
         mem_wr_q   <= mem_wr_d;
         mem_slot_q <= mem_slot_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
      end
   end

   assign bus.mem_wr   = mem_wr_q;
   assign bus.mem_slot = mem_slot_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign cpu_hold     = hold_q;
   assign cart_loaded  = loaded_q;
   assign cart_size    = size_q;
   assign overflow     = ovf_q;
   assign load_done    = done_q;

endmodule

// File: tb/tb_rcastudioii_cart_loader.sv
// Scoreboard bench: download tasks push expected BRAM writes, a negedge monitor pops and compares.
module tb_rcastudioii_cart_loader;

   localparam int DEPTH = 4096;

   typedef struct {
      int slot;
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   logic cpu_hold;
   logic [1:0] cart_loaded;
   logic [12:0] cart_size;
   logic overflow;
   logic load_done;

   rcastudioii_cart_loader_if #(.ADDR_W(12), .SLOT_W(1)) bus ();

   rcastudioii_cart_loader #(
      .ADDR_W(12), .NUM_SLOTS(2), .INDEX_BASE(8'h01), .FILL_BYTE(8'hFF)
   ) dut (
      .clk_sys(clk), .reset(reset), .bus(bus), .cpu_hold(cpu_hold),
      .cart_loaded(cart_loaded), .cart_size(cart_size), .overflow(overflow),
      .load_done(load_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   wr_t exp_q[$];
   wr_t mon_e;
   int done_cnt = 0;
   int hold_cnt = 0;
   int last_addr = 0;

   // Reference model of the externally visible status.
   bit [1:0] m_loaded;
   int m_size;
   bit m_ovf;
   int cur_slot;
   bit cur_inr;
   int cur_size;
   bit cur_ovf;

   function automatic longint pk(input int s, input int a, input int d);
      return (longint'(s) << 20) | (longint'(a) << 8) | longint'(d);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_wr) begin
         last_addr = int'(bus.mem_addr);
         if (exp_q.size() == 0) begin
            check("unexpected_wr", pk(int'(bus.mem_slot), int'(bus.mem_addr), int'(bus.mem_data)), -1);
         end else begin
            mon_e = exp_q.pop_front();
            check("mem_wr", pk(int'(bus.mem_slot), int'(bus.mem_addr), int'(bus.mem_data)),
                  pk(mon_e.slot, mon_e.addr, mon_e.data));
         end
      end
      if (load_done) done_cnt++;
      if (cpu_hold) hold_cnt++;
   end

   task automatic start_dl(input int idx);
      cur_inr  = (idx >= 1) && (idx <= 2);
      cur_slot = idx - 1;
      cur_size = 0;
      cur_ovf  = 1'b0;
      if (cur_inr) m_loaded[cur_slot] = 1'b0;
      bus.ioctl_index    = 8'(idx);
      bus.ioctl_download = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      done_cnt  = 0;
      hold_cnt  = 0;
      last_addr = 0;
   endtask

   task automatic send_bytes(input int n, input int gap_max, input bit pattern, input bit fall_last);
      logic [7:0] d;
      for (int a = 0; a < n; a++) begin
         repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
         d = pattern ? 8'(a) : 8'($urandom);
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'(a);
         bus.ioctl_dout = d;
         if (fall_last && (a == n - 1)) bus.ioctl_download = 1'b0;
         if (cur_inr) begin
            if (a < DEPTH) begin
               exp_q.push_back('{cur_slot, a, int'(d)});
               if (a + 1 > cur_size) cur_size = a + 1;
            end else begin
               cur_ovf = 1'b1;
            end
         end
         @(posedge clk); #1;
         bus.ioctl_wr = 1'b0;
      end
   endtask

   task automatic end_dl();
      bus.ioctl_download = 1'b0;
      if (cur_inr)
         for (int a = cur_size; a < DEPTH; a++) exp_q.push_back('{cur_slot, a, 255});
   endtask

   task automatic finish_dl();
      bit ok = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (cur_inr ? (done_cnt > 0 && exp_q.size() == 0) : (i >= 8)) begin
            ok = 1'b1;
            break;
         end
      end
      check("completion", ok, 1);
      repeat (3) @(negedge clk);
      if (cur_inr) begin
         m_loaded[cur_slot] = (cur_size != 0);
         m_size = cur_size;
         m_ovf  = cur_ovf;
      end
      check("leftover_wr", exp_q.size(), 0);
      check("done_pulses", done_cnt, cur_inr ? 1 : 0);
      check("cart_size", cart_size, m_size);
      check("overflow", overflow, m_ovf);
      check("cart_loaded", cart_loaded, m_loaded);
      check("cpu_hold_idle", cpu_hold, 0);
      if (!cur_inr) check("hold_cycles", hold_cnt, 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_fill_addr(input int target, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (last_addr >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, ok, 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index = '0;
      bus.ioctl_wr = 1'b0;
      bus.ioctl_addr = '0;
      bus.ioctl_dout = '0;
      m_loaded = '0; m_size = 0; m_ovf = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_loaded", cart_loaded, 0);
      check("rst_size", cart_size, 0);
      check("rst_overflow", overflow, 0);
      check("rst_done", load_done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // 512-byte image with data = address, padded to the slot top.
      start_dl(1); send_bytes(512, 0, 1'b1, 1'b0); end_dl(); finish_dl();
      // Full-slot image into slot 1, last byte coincident with the falling edge.
      start_dl(2); send_bytes(DEPTH, 1, 1'b0, 1'b1); end_dl(); finish_dl();
      // Oversized image: tail dropped, overflow flagged.
      start_dl(1); send_bytes(5000, 1, 1'b0, 1'b0); end_dl(); finish_dl();
      // Out-of-range index is ignored entirely.
      start_dl(9); send_bytes(50, 1, 1'b0, 1'b0); end_dl(); finish_dl();
      // Empty download: full fill, slot stays unloaded.
      start_dl(1); send_bytes(0, 0, 1'b0, 1'b0); end_dl(); finish_dl();

      for (int k = 0; k < 3; k++) begin
         start_dl(int'($urandom_range(3, 1)));
         send_bytes(int'($urandom_range(300, 0)), 2, 1'b0, 1'($urandom_range(1, 0)));
         end_dl();
         finish_dl();
      end

      // New download during fill aborts slot 0 and loads slot 1.
      start_dl(1); send_bytes(10, 0, 1'b0, 1'b0); end_dl();
      wait_fill_addr(200, "abort_reach");
      @(posedge clk); #1;
      start_dl(2); send_bytes(64, 1, 1'b0, 1'b0); end_dl(); finish_dl();
      check("abort_slot0_unloaded", cart_loaded[0], 0);

      // Reset mid-fill stops writes and clears status.
      start_dl(1); send_bytes(100, 0, 1'b0, 1'b0); end_dl();
      wait_fill_addr(1000, "reset_reach");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      check("rstmid_mem_wr", bus.mem_wr, 0);
      check("rstmid_cpu_hold", cpu_hold, 0);
      check("rstmid_loaded", cart_loaded, 0);
      check("rstmid_size", cart_size, 0);
      check("rstmid_done", load_done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_mem_wr", bus.mem_wr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
